// File: rtl/booth_mult_sequencer.sv
// booth_mult_sequencer
//   Multi-cycle radix-2 Booth multiplier that sits beside the Execute stage.
//   A MULT in EX raises `start`. The block then holds the front of the pipeline
//   through `stall` until the signed 2*WIDTH-bit product is written to hi/lo.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        EX holds a MULT (level, held while stalled)
//   flush        squash the current multiply (branch taken in MEM)
//   multiplicand EX rs operand, two's complement
//   multiplier   EX rt operand, two's complement
//   stall        freeze PC, IF/ID and ID/EX this cycle
//   busy         FSM is not idle
//   done         one-cycle pulse; product valid in hi/lo
//   hi, lo       upper and lower halves of the product

module booth_mult_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    // One extra accumulator bit so that A - M cannot overflow when M is the most negative value.
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q1_q, q1_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // One Booth step: add/subtract, then arithmetic shift of {A,Q,q_1}.
    logic [WIDTH:0]   a_sum;
    logic [WIDTH:0]   a_shr;
    logic [WIDTH-1:0] q_shr;

    always_comb begin
        unique case ({q_q[0], q1_q})
            2'b01:   a_sum = a_q + m_q;
            2'b10:   a_sum = a_q - m_q;
            default: a_sum = a_q;
        endcase
        a_shr = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_shr = {a_sum[0], q_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        q_d     = q_q;
        q1_d    = q1_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (flush) begin
            // Squash: hi/lo keep the previous product.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        m_d     = {multiplicand[WIDTH-1], multiplicand};
                        a_d     = '0;
                        q_d     = multiplier;
                        q1_d    = 1'b0;
                        count_d = CW'(WIDTH);
                        state_d = StRun;
                    end
                end
                StRun: begin
                    a_d     = a_shr;
                    q_d     = q_shr;
                    q1_d    = q_q[0];
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        hi_d    = a_shr[WIDTH-1:0];
                        lo_d    = q_shr;
                        state_d = StDone;
                    end
                end
                // start is ignored here: it is the same MULT leaving EX at this edge.
                StDone: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Combinational so the MULT is held in EX from its very first cycle.
    assign stall = ((state_q == StIdle && start) || state_q == StRun) && !flush;
    assign busy  = (state_q != StIdle);
    assign done  = (state_q == StDone) && !flush;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Self-checking bench for booth_mult_sequencer (WIDTH = 32).
module tb_booth_mult_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         flush;
    logic [W-1:0] multiplicand;
    logic [W-1:0] multiplier;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_vec = 0;
    int n_err = 0;

    booth_mult_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .flush        (flush),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .stall        (stall),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain signed multiplication.
    function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0]   sa;
        logic signed [W-1:0]   sb;
        logic signed [2*W-1:0] p;
        sa = a;
        sb = b;
        p  = sa * sb;
        return p;
    endfunction

    // Drive and sample on the falling edge, #1 after the inputs settle.
    task automatic step();
        @(negedge clk);
    endtask

    // Full multiply from an IDLE cycle, checking the stall window and latency.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [63:0] exp);
        int bad;
        bad = 0;
        step();
        start = 1'b1; multiplicand = a; multiplier = b;
        #1;
        if (stall !== 1'b1 || done !== 1'b0) bad++;
        for (int c = 1; c <= W; c++) begin
            step();
            #1;
            if (stall !== 1'b1 || done !== 1'b0 || busy !== 1'b1) bad++;
        end
        chk({name, " stall_window_bad_cycles"}, 64'(bad), 64'd0);
        step();
        #1;
        chk({name, " done@W+1"}, {62'd0, done, stall}, 64'b10);
        chk({name, " product"}, {hi, lo}, exp);
        start = 1'b0;
        step();
        #1;
        chk({name, " idle@W+2"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        logic [W-1:0] ra, rb;

        tbl[0] = '{32'd3,        32'd5,        32'h0000_0000, 32'h0000_000F};
        tbl[1] = '{32'hFFFF_FFF9, 32'd6,       32'hFFFF_FFFF, 32'hFFFF_FFD6};
        tbl[2] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        tbl[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};

        reset = 1'b1; start = 1'b0; flush = 1'b0; multiplicand = '0; multiplier = '0;
        step(); step();
        #1;
        chk("reset outputs", {hi, lo}, 64'd0);
        chk("reset flags", {61'd0, stall, busy, done}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, {tbl[i].exp_hi, tbl[i].exp_lo});

        // 3x5, then 2x2 flushed at cycle 10, then 2x2 to completion.
        run_op("pre_flush 3x5", 32'd3, 32'd5, 64'd15);
        step();
        start = 1'b1; multiplicand = 32'd2; multiplier = 32'd2;
        for (int c = 1; c < 10; c++) step();
        flush = 1'b1;
        #1;
        chk("flush cycle stall", 64'(stall), 64'd0);
        step();
        flush = 1'b0; start = 1'b0;
        #1;
        chk("after flush busy/done", {62'd0, busy, done}, 64'd0);
        chk("after flush hi/lo kept", {hi, lo}, 64'd15);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            step(); #1;
            if (done === 1'b1) dones++;
        end
        chk("no done after flush", 64'(dones), 64'd0);
        run_op("post_flush 2x2", 32'd2, 32'd2, 64'd4);

        // start held high across DONE: second op starts in the IDLE cycle after DONE.
        step();
        start = 1'b1; multiplicand = 32'd3; multiplier = 32'd5;
        dones = 0;
        for (int c = 1; c <= 2 * (W + 2) - 1; c++) begin
            step();
            if (c == W + 2) begin
                multiplicand = 32'hFFFF_FFF9; multiplier = 32'd6;
            end
            #1;
            if (done === 1'b1) dones++;
            if (c == W + 1) chk("b2b first product", {hi, lo}, 64'd15);
            if (c == W + 2) chk("b2b restart stall/busy", {62'd0, stall, busy}, 64'b10);
        end
        chk("b2b second done", 64'(done), 64'd1);
        chk("b2b second product", {hi, lo}, ref_mul(32'hFFFF_FFF9, 32'd6));
        chk("b2b done count", 64'(dones), 64'd2);
        start = 1'b0;
        step();

        // Randomised operands against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 1) ra = 32'h8000_0000;
            if (i % 7 == 2) rb = 32'hFFFF_FFFF;
            run_op($sformatf("rand%0d 0x%0h*0x%0h", i, ra, rb), ra, rb, ref_mul(ra, rb));
        end

        // Reset during RUN cycle 5 clears everything, including hi/lo.
        step();
        start = 1'b1; multiplicand = 32'd7; multiplier = 32'd9;
        for (int c = 1; c <= 5; c++) step();
        reset = 1'b1; start = 1'b0;
        step();
        reset = 1'b0;
        #1;
        chk("reset mid-run hi/lo", {hi, lo}, 64'd0);
        chk("reset mid-run flags", {61'd0, stall, busy, done}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
